mcu_timer_array: RTL and testbench

//   Parametrised multi-channel timer/PWM peripheral; successor to the single-channel MCU timer.
//   N_CH independent down-counters, each with one-shot, periodic and PWM modes, a shared prescaler,
//   per-channel interrupt pending flags and one PWM pin per channel. Sits on the controller's
//   cs/wr/rd peripheral bus beside Ram/Rom; irq feeds the controller's timer interrupt input.

---
 rtl/mcu_timer_array.sv | 148 ++++++++++++++
 tb/tb_mcu_timer_array.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcu_timer_array.sv
// Multi-channel timer/PWM peripheral on the cs/wr/rd bus.
// There are N_CH independent down-counters that share one prescaler tick.
// Each channel has one-shot, periodic and PWM modes, a pending flag and a PWM pin.

module mcu_timer_ch #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             wrCtrl,
  input  logic             wrReload,
  input  logic             wrCompare,
  input  logic             wrStatus,
  input  logic [WIDTH-1:0] wdata,
  output logic             en,
  output logic [1:0]       mode,
  output logic             irqEn,
  output logic [WIDTH-1:0] reload,
  output logic [WIDTH-1:0] compare,
  output logic [WIDTH-1:0] count,
  output logic             pend,
  output logic             pwm
);
  logic start, freeze, run, expire;

  // Writing en 0->1 restarts the channel. Writing en=0 stops it on the same edge.
  assign start  = wrCtrl & wdata[0] & ~en;
  assign freeze = wrCtrl & ~wdata[0];
  assign run    = en & tick & ~freeze;
  assign expire = run & (count == '0);

  // Channel registers, the down-counter, the pending flag and the PWM pin.
  // Counting uses the mode and reload value held before this edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en      <= 1'b0;
      mode    <= 2'b00;
      irqEn   <= 1'b0;
      reload  <= '0;
      compare <= '0;
      count   <= '0;
      pend    <= 1'b0;
      pwm     <= 1'b0;
    end else begin
      if (wrCtrl) begin
        en    <= wdata[0];
        mode  <= wdata[2:1];
        irqEn <= wdata[3];
      end
      if (wrReload)  reload  <= wdata;
      if (wrCompare) compare <= wdata;
      if (start) count <= reload;
      else if (run) begin
        if (count != '0) count <= count - WIDTH'(1);
        else if (mode == 2'b00) en <= 1'b0;
        else count <= reload;
      end
      // When an expiry and a clear land on the same edge, the expiry wins.
      if (wrStatus & wdata[0]) pend <= 1'b0;
      if (expire) pend <= 1'b1;
      pwm <= en & (mode == 2'b10) & (count < compare);
    end
  end
endmodule

module mcu_timer_array #(
  parameter int N_CH     = 4,
  parameter int WIDTH    = 16,
  parameter int PRESCALE = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cs,
  input  logic                     wr,
  input  logic                     rd,
  input  logic [$clog2(N_CH)+2:0]  addr,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     irq,
  output logic [N_CH-1:0]          pwm_out
);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] psc;
  logic          tick;
  int            chSel;
  logic [2:0]    regSel;
  logic [WIDTH-1:0] rdVal;

  logic [N_CH-1:0]            enA, ieA, pendA, pwmA;
  logic [N_CH-1:0][1:0]       modeA;
  logic [N_CH-1:0][WIDTH-1:0] reloadA, compareA, countA;

  assign tick   = (psc == PW'(PRESCALE - 1));
  assign chSel  = int'(addr >> 3);
  assign regSel = addr[2:0];

  // Free-running prescaler. Channels advance only on the wrap cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       psc <= '0;
    else if (tick) psc <= '0;
    else           psc <= psc + PW'(1);
  end

  for (genvar i = 0; i < N_CH; i++) begin : gCh
    logic hit;
    assign hit = cs & wr & (chSel == i);
    mcu_timer_ch #(.WIDTH(WIDTH)) uCh (
      .clk(clk), .rst(rst), .tick(tick),
      .wrCtrl(hit & (regSel == 3'd0)),
      .wrReload(hit & (regSel == 3'd1)),
      .wrCompare(hit & (regSel == 3'd2)),
      .wrStatus(hit & (regSel == 3'd4)),
      .wdata(wdata),
      .en(enA[i]), .mode(modeA[i]), .irqEn(ieA[i]),
      .reload(reloadA[i]), .compare(compareA[i]), .count(countA[i]),
      .pend(pendA[i]), .pwm(pwmA[i])
    );
  end

  // Read mux. A channel index that is out of range and registers 5-7 read as zero.
  always_comb begin
    rdVal = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (chSel == i) begin
        case (regSel)
          3'd0:    rdVal = {{(WIDTH-4){1'b0}}, ieA[i], modeA[i], enA[i]};
          3'd1:    rdVal = reloadA[i];
          3'd2:    rdVal = compareA[i];
          3'd3:    rdVal = countA[i];
          3'd4:    rdVal = {{(WIDTH-1){1'b0}}, pendA[i]};
          default: rdVal = '0;
        endcase
      end
    end
  end

  // Registered read data. It holds until the next read.
  // On a simultaneous write it returns the value from before the write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          rdata <= '0;
    else if (cs & rd) rdata <= rdVal;
  end

  assign irq     = |(pendA & ieA);
  assign pwm_out = pwmA;
endmodule

// File: tb/tb_mcu_timer_array.sv
// Bench for mcu_timer_array. It has two instances (PRESCALE 1 and 4) that share one bus.
// It runs register vectors, directed timing sequences and random bus traffic.
// The random traffic is checked against a reference model built from arrays.

module tb_mcu_timer_array;
  localparam int N = 4, W = 16, AW = 5;

  logic clk = 1'b0, rst = 1'b1, cs = 1'b0, wr = 1'b0, rd = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [W-1:0]  wdata = '0;
  logic [W-1:0]  rdA, rdB;
  logic          irqA, irqB;
  logic [N-1:0]  pwmA, pwmB;

  always #5 clk = ~clk;

  mcu_timer_array #(.N_CH(N), .WIDTH(W), .PRESCALE(1)) dutA (
    .clk(clk), .rst(rst), .cs(cs), .wr(wr), .rd(rd), .addr(addr), .wdata(wdata),
    .rdata(rdA), .irq(irqA), .pwm_out(pwmA));
  mcu_timer_array #(.N_CH(N), .WIDTH(W), .PRESCALE(4)) dutB (
    .clk(clk), .rst(rst), .cs(cs), .wr(wr), .rd(rd), .addr(addr), .wdata(wdata),
    .rdata(rdB), .irq(irqB), .pwm_out(pwmB));

  int nChk = 0, nFail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChk++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Architectural view of each instance k. Only the values visible through the
  // register file are kept, and they are updated once per clock edge.
  int mEn[2][N], mMode[2][N], mIe[2][N], mRel[2][N], mCmp[2][N], mCnt[2][N];
  int mPend[2][N], mPwm[2][N], mPsc[2], mRd[2];
  bit modelChk = 1'b0;

  function automatic int regVal(input int k, input int c, input int r);
    case (r)
      0: return mIe[k][c] * 8 + mMode[k][c] * 2 + mEn[k][c];
      1: return mRel[k][c];
      2: return mCmp[k][c];
      3: return mCnt[k][c];
      4: return mPend[k][c];
      default: return 0;
    endcase
  endfunction

  task automatic modelStep(input int k);
    automatic int pk = (k == 1) ? 4 : 1;
    automatic bit tk = (mPsc[k] == pk - 1);
    automatic int ch = int'(addr) >> 3;
    automatic int r  = int'(addr) & 7;
    if (cs && rd) mRd[k] = regVal(k, ch, r);
    for (int c = 0; c < N; c++) begin
      automatic int  oEn = mEn[k][c], oMode = mMode[k][c], oCnt = mCnt[k][c], oRel = mRel[k][c];
      automatic bit  hit = cs && wr && (ch == c);
      automatic bit  start = 0, stopped = 0, expire = 0, clr = 0;
      mPwm[k][c] = (oEn == 1 && oMode == 2 && oCnt < mCmp[k][c]) ? 1 : 0;
      if (hit) begin
        case (r)
          0: begin
            start   = (oEn == 0) && wdata[0];
            stopped = !wdata[0];
            mEn[k][c] = int'(wdata[0]); mMode[k][c] = int'(wdata[2:1]); mIe[k][c] = int'(wdata[3]);
          end
          1: mRel[k][c] = int'(wdata);
          2: mCmp[k][c] = int'(wdata);
          4: clr = wdata[0];
          default: ;
        endcase
      end
      if (start) mCnt[k][c] = oRel;
      else if (oEn == 1 && tk && !stopped) begin
        if (oCnt > 0) mCnt[k][c] = oCnt - 1;
        else begin
          expire = 1;
          if (oMode == 0) mEn[k][c] = 0; else mCnt[k][c] = oRel;
        end
      end
      if (clr) mPend[k][c] = 0;
      if (expire) mPend[k][c] = 1;
    end
    mPsc[k] = (mPsc[k] + 1) % pk;
  endtask

  // Advance the model on every edge. Reset clears all state.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        mPsc[k] = 0; mRd[k] = 0;
        for (int c = 0; c < N; c++) begin
          mEn[k][c] = 0; mMode[k][c] = 0; mIe[k][c] = 0; mRel[k][c] = 0;
          mCmp[k][c] = 0; mCnt[k][c] = 0; mPend[k][c] = 0; mPwm[k][c] = 0;
        end
      end
    end else begin
      modelStep(0);
      modelStep(1);
    end
  end

  function automatic logic modelIrq(input int k);
    logic v = 1'b0;
    for (int c = 0; c < N; c++) v |= (mPend[k][c] == 1 && mIe[k][c] == 1);
    return v;
  endfunction

  function automatic logic [N-1:0] modelPwm(input int k);
    logic [N-1:0] v = '0;
    for (int c = 0; c < N; c++) v[c] = (mPwm[k][c] == 1);
    return v;
  endfunction

  // During the random phase, compare both instances with the model on every falling edge.
  always @(negedge clk) begin
    if (modelChk && !rst) begin
      check("rnd_rdata_A", 32'(rdA), mRd[0]);
      check("rnd_irq_A", 32'(irqA), 32'(modelIrq(0)));
      check("rnd_pwm_A", 32'(pwmA), 32'(modelPwm(0)));
      check("rnd_rdata_B", 32'(rdB), mRd[1]);
      check("rnd_irq_B", 32'(irqB), 32'(modelIrq(1)));
      check("rnd_pwm_B", 32'(pwmB), 32'(modelPwm(1)));
    end
  end

  // ---------------- bus helpers (entered on a falling edge) ----------------
  task automatic wrReg(input int ch, input int r, input int d);
    cs = 1; wr = 1; rd = 0; addr = AW'(ch * 8 + r); wdata = W'(d);
    @(negedge clk);
    cs = 0; wr = 0;
  endtask

  task automatic rdReg(input int ch, input int r);
    cs = 1; rd = 1; wr = 0; addr = AW'(ch * 8 + r);
    @(negedge clk);
    cs = 0; rd = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic doReset();
    rst = 1; @(negedge clk); rst = 0;
  endtask

  typedef struct { int ch; int r; int wd; int exp; } vec_t;
  vec_t tbl[10];

  initial begin
    automatic int hi, t;
    tbl[0] = '{0, 1, 'h1234, 'h1234};
    tbl[1] = '{1, 2, 'hBEEF, 'hBEEF};
    tbl[2] = '{2, 3, 'h5555, 0};
    tbl[3] = '{3, 5, 'hFFFF, 0};
    tbl[4] = '{0, 6, 'hFFFF, 0};
    tbl[5] = '{1, 7, 'hFFFF, 0};
    tbl[6] = '{1, 0, 'hFFF6, 'h0006};
    tbl[7] = '{2, 0, 'h000C, 'h000C};
    tbl[8] = '{3, 4, 'h0001, 0};
    tbl[9] = '{3, 1, 'hFFFF, 'hFFFF};

    @(negedge clk); @(negedge clk);
    check("reset_rdata", 32'(rdA), 0); check("reset_irq", 32'(irqA), 0);
    check("reset_pwm", 32'(pwmA), 0);  check("reset_rdata_B", 32'(rdB), 0);
    rst = 0;

    // Register access vectors: write, then read back.
    foreach (tbl[i]) begin
      wrReg(tbl[i].ch, tbl[i].r, tbl[i].wd);
      rdReg(tbl[i].ch, tbl[i].r);
      check("tbl_read_A", 32'(rdA), tbl[i].exp);
      check("tbl_read_B", 32'(rdB), tbl[i].exp);
    end
    // A read and a write on the same edge return the old value.
    cs = 1; wr = 1; rd = 1; addr = AW'(1); wdata = 16'h4321;
    @(negedge clk); cs = 0; wr = 0; rd = 0;
    check("rw_old_value", 32'(rdA), 'h1234);
    rdReg(0, 1); check("rw_new_value", 32'(rdA), 'h4321);
    idle(2);     check("rdata_hold", 32'(rdA), 'h4321);

    // T1: periodic channel, RELOAD=3
    doReset();
    wrReg(0, 1, 3);
    wrReg(0, 0, 'b1011);
    for (int i = 0; i < 4; i++) begin
      rdReg(0, 3); check("t1_count", 32'(rdA), 3 - i);
    end
    check("t1_irq_set", 32'(irqA), 1);
    rdReg(0, 3); check("t1_reloaded", 32'(rdA), 3);
    rdReg(0, 4); check("t1_pend", 32'(rdA), 1);
    wrReg(0, 4, 1); check("t1_irq_cleared", 32'(irqA), 0);
    wrReg(0, 0, 0); idle(2); check("t1_stopped", 32'(irqA), 0);

    // T2: one-shot channel, RELOAD=2
    doReset();
    wrReg(1, 1, 2);
    wrReg(1, 0, 'b1001);
    idle(2); check("t2_no_early_pend", 32'(irqA), 0);
    idle(1); check("t2_pend", 32'(irqA), 1);
    rdReg(1, 0); check("t2_en_cleared", 32'(rdA), 8);
    rdReg(1, 3); check("t2_count_zero", 32'(rdA), 0);
    wrReg(1, 4, 1); idle(6);
    check("t2_no_repend", 32'(irqA), 0);
    rdReg(1, 4); check("t2_status", 32'(rdA), 0);

    // T3: PWM channel, RELOAD=9
    doReset();
    wrReg(2, 1, 9); wrReg(2, 2, 3); wrReg(2, 0, 'b0101);
    idle(3);
    hi = 0; repeat (20) begin @(negedge clk); hi += int'(pwmA[2]); end
    check("t3_duty_3of10", hi, 6);
    check("t3_other_pins", 32'(pwmA & 4'b1011), 0);
    wrReg(2, 2, 0); idle(2);
    hi = 0; repeat (20) begin @(negedge clk); hi += int'(pwmA[2]); end
    check("t3_cmp0_low", hi, 0);
    wrReg(2, 2, 12); idle(2);
    hi = 0; repeat (20) begin @(negedge clk); hi += int'(pwmA[2]); end
    check("t3_cmp_gt_reload_high", hi, 20);

    // T4: PRESCALE=4 instance, RELOAD=1 expires every 8 clocks
    doReset();
    wrReg(0, 1, 1); wrReg(0, 0, 'b1011);
    t = 0;
    while (!irqB && t < 40) begin @(negedge clk); t++; end
    check("t4_first_expiry", 32'(irqB), 1);
    wrReg(0, 4, 1);
    idle(6); check("t4_no_early", 32'(irqB), 0);
    idle(1); check("t4_period_8", 32'(irqB), 1);
    idle(3);
    rdReg(0, 3); check("t4_read_count1", 32'(rdB), 1);
    rdReg(0, 3); check("t4_read_count0", 32'(rdB), 0);
    idle(3);     check("t4_rdata_holds", 32'(rdB), 0);

    // T5: a clear on the same edge as an expiry leaves pend set; irq_en gating
    doReset();
    wrReg(3, 1, 2); wrReg(3, 0, 'b1011);
    idle(3); check("t5_first", 32'(irqA), 1);
    idle(2);
    wrReg(3, 4, 1); check("t5_set_wins", 32'(irqA), 1);
    wrReg(3, 4, 1); check("t5_cleared", 32'(irqA), 0);
    wrReg(3, 0, 0);
    wrReg(3, 0, 'b0011);
    idle(4); check("t5_masked_irq", 32'(irqA), 0);
    rdReg(3, 4); check("t5_masked_pend", 32'(rdA), 1);
    wrReg(3, 0, 0);

    // T6: reset asserted between edges while counting
    doReset();
    wrReg(0, 1, 5); wrReg(0, 2, 10); wrReg(0, 0, 'b1101);
    idle(7);
    check("t6_pre_irq", 32'(irqA), 1);
    check("t6_pre_pwm", 32'(pwmA[0]), 1);
    rdReg(0, 1); check("t6_pre_rdata", 32'(rdA), 5);
    #2 rst = 1;
    #1;
    check("t6_rdata", 32'(rdA), 0); check("t6_irq", 32'(irqA), 0);
    check("t6_pwm", 32'(pwmA), 0);  check("t6_rdata_B", 32'(rdB), 0);
    check("t6_irq_B", 32'(irqB), 0); check("t6_pwm_B", 32'(pwmB), 0);
    @(negedge clk); rst = 0;
    rdReg(0, 3); check("t6_count", 32'(rdA), 0);
    rdReg(0, 0); check("t6_ctrl", 32'(rdA), 0);
    rdReg(0, 4); check("t6_pend", 32'(rdA), 0);
    idle(10);
    check("t6_idle_irq", 32'(irqA | irqB), 0);
    check("t6_idle_pwm", 32'(pwmA | pwmB), 0);

    // Random bus traffic checked against the model.
    doReset();
    modelChk = 1'b1;
    repeat (3000) begin
      automatic int r = $urandom_range(0, 7);
      cs = ($urandom_range(0, 1) == 1);
      wr = ($urandom_range(0, 2) == 0);
      rd = ($urandom_range(0, 1) == 1);
      addr = AW'($urandom_range(0, N - 1) * 8 + r);
      case (r)
        0: wdata = W'($urandom_range(0, 15));
        1: wdata = W'($urandom_range(0, 6));
        2: wdata = W'($urandom_range(0, 8));
        4: wdata = W'($urandom_range(0, 1));
        default: wdata = W'($urandom);
      endcase
      @(negedge clk);
    end
    cs = 0; wr = 0; rd = 0;
    modelChk = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", nChk, nFail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
